// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD     = 3'd2,
        ST_RD_CAP = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way request picker: round-robin by default, fixed priority to
// requester 0 when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic               win,
    output logic               valid
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        valid = |req;
        win   = ~req[0];
    end
`else
    // ptr names the favoured requester when both are asking.
    always_comb begin
        valid = |req;
        win   = (&req) ? ptr : req[1];
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two masters onto one single-port RAM; one command per access.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8,
    parameter int SIZE      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDRWIDTH-1:0] addr0,
    input  logic [ADDRWIDTH-1:0] addr1,
    input  logic [DATAWIDTH-1:0] wdata0,
    input  logic [DATAWIDTH-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 err,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 busy,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic                 ram_oe,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_dout,
    output logic                 ram_dout_en,
    input  logic [DATAWIDTH-1:0] ram_din,
    output state_t               state
);

    localparam logic [ADDRWIDTH:0] SIZE_L = (ADDRWIDTH+1)'(SIZE);

    state_t               state_q;
    logic                 ptr_q;
    logic                 win_q;
    logic                 err_q;
    logic                 win;
    logic                 win_valid;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [DATAWIDTH-1:0] sel_wdata;
    logic                 sel_we;
    logic                 oor;

    ram_arb_rr u_rr (
        .req   ({req1, req0}),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_valid)
    );

    always_comb begin
        sel_addr  = win ? addr1  : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        sel_we    = win ? we1    : we0;
        oor       = {1'b0, sel_addr} >= SIZE_L;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            err_q    <= 1'b0;
            ram_addr <= '0;
            ram_dout <= '0;
            rdata    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        win_q    <= win;
                        ram_addr <= sel_addr;
                        ram_dout <= sel_wdata;
                        err_q    <= oor;
                        // Out-of-range accesses skip the RAM entirely.
                        if (oor) begin
                            if (!sel_we) rdata <= '0;
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= sel_we ? ST_WR : ST_RD;
                        end
                    end
                end
                ST_WR:     state_q <= ST_ACK;
                ST_RD:     state_q <= ST_RD_CAP;
                ST_RD_CAP: begin
                    rdata   <= ram_din;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    ptr_q   <= ~win_q;
                    state_q <= ST_IDLE;
                end
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Write drive and output enable come from disjoint states, so the bus never contends.
    always_comb begin
        state       = state_q;
        busy        = (state_q != ST_IDLE);
        ram_cs      = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_RD_CAP);
        ram_we      = (state_q == ST_WR);
        ram_oe      = (state_q == ST_RD) || (state_q == ST_RD_CAP);
        ram_dout_en = (state_q == ST_WR);
        ack0        = (state_q == ST_ACK) && !win_q;
        ack1        = (state_q == ST_ACK) &&  win_q;
        err         = (state_q == ST_ACK) &&  err_q;
    end

endmodule
